// File: rtl/fft_pkg.sv
// Shared types and helpers for the fft output-side streaming blocks.
// A sample is one 32-bit word holding a 16-bit real part (upper) and a 16-bit imaginary part (lower).
package fft_pkg;

    localparam int SAMPLE_W = 32;
    localparam int COMP_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        STREAM  = 2'd3
    } state_t;

    // Reverse the low 'width' bits of idx; bits above width come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[width-1-i] = idx[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_streamer_if.sv
// Valid/ready sample stream carrying one complex fft bin per beat.
interface fft_frame_streamer_if #(
    parameter int IDX_W = 3
);
    import fft_pkg::*;

    logic                     s_valid;
    logic                     s_ready;
    logic signed [COMP_W-1:0] s_real;
    logic signed [COMP_W-1:0] s_imag;
    logic [IDX_W-1:0]         s_index;
    logic                     s_last;

    modport master (
        output s_valid, s_real, s_imag, s_index, s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_real, s_imag, s_index, s_last,
        output s_ready
    );

endinterface

// File: rtl/fft_bitrev_idx.sv
// Combinational bit-reversal of a W-bit index; shared by the output streamer and input-side loaders.
module fft_bitrev_idx
    import fft_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0] i_idx,
    output logic [W-1:0] o_idx
);

    assign o_idx = W'(bitrev(32'(i_idx), W));

endmodule

// File: rtl/fft_frame_streamer.sv
// Arms on an enable rising edge, waits out the fft latency, freezes the parallel result
// and streams it one complex sample per valid/ready beat.
module fft_frame_streamer
    import fft_pkg::*;
#(
    parameter int LEN     = 8,
    parameter int LATENCY = 10,
    parameter int BITREV  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [LEN*SAMPLE_W-1:0]   dataout,
    fft_frame_streamer_if.master      s,
    output logic                      busy,
    output logic                      overrun
);

    localparam int IDX_W = $clog2(LEN);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t                    r_state;
    logic                      r_en_q;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_ptr;
    logic [LEN*SAMPLE_W-1:0]   r_frame;
    logic                      r_s_valid;
    logic signed [COMP_W-1:0]  r_s_real;
    logic signed [COMP_W-1:0]  r_s_imag;
    logic [IDX_W-1:0]          r_s_index;
    logic                      r_s_last;
    logic                      r_busy;
    logic                      r_overrun;

    logic                      w_rise;
    logic                      w_hs;
    logic [IDX_W-1:0]          w_ptr_nxt;
    logic [IDX_W-1:0]          w_rev_nxt;
    logic [IDX_W-1:0]          w_addr_nxt;
    logic [SAMPLE_W-1:0]       w_sample_nxt;

    assign w_rise       = enable & ~r_en_q;
    assign w_hs         = r_s_valid & s.s_ready;
    assign w_ptr_nxt    = r_ptr + IDX_W'(1);
    assign w_addr_nxt   = (BITREV != 0) ? w_rev_nxt : w_ptr_nxt;
    assign w_sample_nxt = r_frame[SAMPLE_W*w_addr_nxt +: SAMPLE_W];

    fft_bitrev_idx #(.W(IDX_W)) u_bitrev (
        .i_idx (w_ptr_nxt),
        .o_idx (w_rev_nxt)
    );

    // Frame FSM; every stream output is loaded one beat ahead so nothing is combinational from inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_en_q    <= 1'b0;
            r_cnt     <= CNT_W'(0);
            r_ptr     <= IDX_W'(0);
            r_frame   <= '0;
            r_s_valid <= 1'b0;
            r_s_real  <= COMP_W'(0);
            r_s_imag  <= COMP_W'(0);
            r_s_index <= IDX_W'(0);
            r_s_last  <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_en_q <= enable;
            if (w_rise && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= WAIT;
                        r_cnt   <= CNT_W'(LATENCY - 1);
                        r_busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_W'(0)) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    // Index 0 maps to itself in both orders, so beat 0 comes straight from the capture.
                    r_frame   <= dataout;
                    r_ptr     <= IDX_W'(0);
                    r_state   <= STREAM;
                    r_s_valid <= 1'b1;
                    r_s_real  <= dataout[COMP_W +: COMP_W];
                    r_s_imag  <= dataout[0 +: COMP_W];
                    r_s_index <= IDX_W'(0);
                    r_s_last  <= 1'b0;
                end
                STREAM: begin
                    if (w_hs) begin
                        if (r_ptr == IDX_W'(LEN - 1)) begin
                            r_state   <= IDLE;
                            r_s_valid <= 1'b0;
                            r_s_last  <= 1'b0;
                            r_busy    <= 1'b0;
                        end else begin
                            r_ptr     <= w_ptr_nxt;
                            r_s_real  <= w_sample_nxt[COMP_W +: COMP_W];
                            r_s_imag  <= w_sample_nxt[0 +: COMP_W];
                            r_s_index <= w_addr_nxt;
                            r_s_last  <= (w_ptr_nxt == IDX_W'(LEN - 1));
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_s_valid <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign s.s_valid = r_s_valid;
    assign s.s_real  = r_s_real;
    assign s.s_imag  = r_s_imag;
    assign s.s_index = r_s_index;
    assign s.s_last  = r_s_last;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Scoreboard bench: a natural-order and a bit-reversed streamer run side by side on the same stimulus.
module tb_fft_frame_streamer;
    import fft_pkg::*;

    localparam int LEN = 8;
    localparam int IW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic ready = 1'b0;
    logic [LEN*SAMPLE_W-1:0] dataout;
    logic busy0, ovr0, busy1, ovr1;

    int n_vec = 0;
    int n_err = 0;

    logic [35:0] q0[$];
    logic [35:0] q1[$];
    logic        stall_prev[2];
    logic [35:0] stall_val[2];
    int          rev_tab[LEN] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always #5 clk = ~clk;

    fft_frame_streamer_if #(.IDX_W(IW)) if0 ();
    fft_frame_streamer_if #(.IDX_W(IW)) if1 ();

    assign if0.s_ready = ready;
    assign if1.s_ready = ready;

    fft_frame_streamer #(.LEN(LEN), .LATENCY(10), .BITREV(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .dataout(dataout),
        .s(if0), .busy(busy0), .overrun(ovr0)
    );

    fft_frame_streamer #(.LEN(LEN), .LATENCY(10), .BITREV(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .dataout(dataout),
        .s(if1), .busy(busy1), .overrun(ovr1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats: sample j carries real=j+1, imag=-j; last flags the eighth beat in either order.
    task automatic push_frame();
        for (int k = 0; k < LEN; k++) begin
            int r;
            r = rev_tab[k];
            q0.push_back({3'(k), (k == LEN - 1), 16'(k + 1), 16'(-k)});
            q1.push_back({3'(r), (k == LEN - 1), 16'(r + 1), 16'(-r)});
        end
    endtask

    function automatic logic [35:0] tup(input int d);
        if (d == 0) return {if0.s_index, if0.s_last, if0.s_real, if0.s_imag};
        else        return {if1.s_index, if1.s_last, if1.s_real, if1.s_imag};
    endfunction

    // Monitor: pops on every handshake and checks outputs hold steady across stalls.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic        v;
            logic [35:0] t;
            logic [35:0] e;
            v = (d == 0) ? if0.s_valid : if1.s_valid;
            t = tup(d);
            if (rst) begin
                stall_prev[d] = 1'b0;
            end else begin
                if (stall_prev[d]) begin
                    chk($sformatf("stall_hold_dut%0d", d), {27'd0, v, t}, {27'd0, 1'b1, stall_val[d]});
                end
                if (v && ready) begin
                    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat_dut%0d: got %h expected no beat at %0t", d, t, $time);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("beat_dut%0d", d), {28'd0, t}, {28'd0, e});
                    end
                end
                stall_prev[d] = v && !ready;
                stall_val[d]  = t;
            end
        end
    end

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_dut0"}, {if0.s_valid, tup(0), busy0, ovr0}, 64'd0);
        chk({nm, "_dut1"}, {if1.s_valid, tup(1), busy1, ovr1}, 64'd0);
    endtask

    initial begin
        for (int j = 0; j < LEN; j++) begin
            dataout[32*j +: 32] = {16'(j + 1), 16'(-j)};
        end
        stall_prev[0] = 1'b0;
        stall_prev[1] = 1'b0;

        // Reset state
        repeat (3) tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Natural and bit-reversed frames with ready held high; check exact latency
        push_frame();
        ready  = 1'b1;
        enable = 1'b1;
        repeat (11) tick();
        chk("valid_before_cycle12", {if0.s_valid, if1.s_valid}, 2'b00);
        tick();
        chk("valid_at_cycle12", {if0.s_valid, if1.s_valid}, 2'b11);
        repeat (8) tick();
        chk("busy_low_cycle20", {busy0, busy1}, 2'b00);
        chk("drained_frame1", q0.size() + q1.size(), 0);
        chk("no_overrun_frame1", {ovr0, ovr1}, 2'b00);

        // Backpressure: ready 1,0,0 repeating
        enable = 1'b0;
        repeat (2) tick();
        push_frame();
        enable = 1'b1;
        for (int c = 0; c < 100 && (q0.size() != 0 || q1.size() != 0); c++) begin
            ready = (c % 3 == 0);
            tick();
        end
        ready = 1'b1;
        tick();
        chk("drained_backpressure", q0.size() + q1.size(), 0);
        chk("idle_after_backpressure", {busy0, busy1, if0.s_valid, if1.s_valid}, 4'b0000);

        // Abort: enable low at cycle 5
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        repeat (5) tick();
        chk("busy_in_wait", {busy0, busy1}, 2'b11);
        enable = 1'b0;
        tick();
        chk("abort_idle", {busy0, busy1}, 2'b00);
        repeat (20) tick();
        chk("abort_no_overrun", {ovr0, ovr1}, 2'b00);

        // Overrun: second rise while streaming beat 3
        push_frame();
        enable = 1'b1;
        repeat (13) tick();
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        tick();
        chk("overrun_set", {ovr0, ovr1}, 2'b11);
        repeat (10) tick();
        chk("drained_overrun", q0.size() + q1.size(), 0);
        repeat (20) tick();
        chk("single_frame_overrun", {busy0, busy1, if0.s_valid, if1.s_valid}, 4'b0000);

        // Asynchronous reset mid-stream after beat 2, then a clean frame
        enable = 1'b0;
        repeat (2) tick();
        push_frame();
        enable = 1'b1;
        repeat (15) tick();
        chk("mid_stream_q_left", q0.size(), 5);
        #3;
        rst = 1'b1;
        #1;
        chk_idle_outputs("async_reset");
        q0.delete();
        q1.delete();
        enable = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        push_frame();
        enable = 1'b1;
        for (int c = 0; c < 40 && (q0.size() != 0 || q1.size() != 0); c++) begin
            tick();
        end
        chk("drained_after_reset", q0.size() + q1.size(), 0);
        tick();
        chk("idle_after_reset_frame", {busy0, busy1, ovr0, ovr1}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
